// File: rtl/fpu_stripe_sequencer.sv
// Stripe sequencer for one FPU filter pass: hands ping-pong column buffers between the
// memory side and the shift/MAC datapath, one stripe at a time.
module fpu_stripe_sequencer #(
  parameter int unsigned MEM_BUFFER_WIDTH = 512,
  parameter int unsigned COL_WIDTH        = 10,
  parameter int unsigned MAC_LATENCY      = 2,
  localparam int unsigned AW = $clog2(MEM_BUFFER_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   row_width,
  input  logic [15:0]   num_stripes,
  input  logic [1:0]    rd_buf_ready,
  input  logic [1:0]    wr_buf_free,
  output logic [1:0]    rd_buf_release,
  output logic [1:0]    wr_buf_commit,
  output logic          rd_buffer_sel,
  output logic          wr_buffer_sel,
  output logic [AW-1:0] read_col_address,
  output logic [AW-1:0] write_col_address,
  output logic          shift_cols,
  output logic          wr_en_wr_buffer,
  output logic          busy,
  output logic          done
);

  if (MAC_LATENCY < 1 || COL_WIDTH < 1) begin : g_param_check
    $error("fpu_stripe_sequencer: MAC_LATENCY and COL_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_STREAM, S_FLUSH, S_COMMIT, S_DONE
  } state_t;

  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] TWO   = (AW+1)'(2);
  localparam logic [AW:0] THREE = (AW+1)'(3);

  state_t            state_q, state_d;
  logic [AW:0]       row_w_q, row_w_d;
  logic [15:0]       stripes_q, stripes_d;
  logic [15:0]       stripe_cnt_q, stripe_cnt_d;
  logic              rd_sel_q, rd_sel_d;
  logic              wr_sel_q, wr_sel_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic [AW:0]       shift_cnt_q, shift_cnt_d;
  logic              shift_q, shift_d;
  logic [AW-1:0]     rd_last_q, rd_last_d;
  logic [AW-1:0]     wr_last_q, wr_last_d;
  logic [MAC_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [AW-1:0]     pipe_addr_q [MAC_LATENCY];
  logic [AW-1:0]     pipe_addr_d [MAC_LATENCY];

  logic              wr_en_int;
  logic [AW-1:0]     wr_addr_int;

  assign wr_en_int   = pipe_vld_q[MAC_LATENCY-1];
  assign wr_addr_int = pipe_addr_q[MAC_LATENCY-1];

  always_comb begin
    state_d      = state_q;
    row_w_d      = row_w_q;
    stripes_d    = stripes_q;
    stripe_cnt_d = stripe_cnt_q;
    rd_sel_d     = rd_sel_q;
    wr_sel_d     = wr_sel_q;
    rd_cnt_d     = rd_cnt_q;
    shift_cnt_d  = shift_cnt_q;
    rd_last_d    = rd_last_q;
    wr_last_d    = wr_last_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_addr_d  = pipe_addr_q;
    shift_d      = (state_q == S_STREAM);

    // Shift k (1-based, k>=3) completes result column k-3 after MAC_LATENCY cycles.
    if (shift_q) shift_cnt_d = shift_cnt_q + ONE;
    pipe_vld_d[0]  = shift_q && (shift_cnt_q >= TWO);
    pipe_addr_d[0] = AW'(shift_cnt_q - TWO);
    for (int unsigned i = 1; i < MAC_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    if (wr_en_int) wr_last_d = wr_addr_int;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_w_d      = row_width;
          stripes_d    = num_stripes;
          rd_sel_d     = 1'b0;
          wr_sel_d     = 1'b0;
          stripe_cnt_d = '0;
          state_d      = (row_width < THREE || num_stripes == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        rd_cnt_d    = '0;
        shift_cnt_d = '0;
        if (rd_buf_ready[rd_sel_q] && wr_buf_free[wr_sel_q]) state_d = S_STREAM;
      end
      S_STREAM: begin
        rd_last_d = rd_cnt_q[AW-1:0];
        rd_cnt_d  = rd_cnt_q + ONE;
        if (rd_cnt_q == row_w_q - ONE) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (wr_en_int && ({1'b0, wr_addr_int} == row_w_q - THREE)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        rd_sel_d     = ~rd_sel_q;
        wr_sel_d     = ~wr_sel_q;
        stripe_cnt_d = stripe_cnt_q + 16'd1;
        state_d      = (stripe_cnt_q == stripes_q - 16'd1) ? S_DONE : S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_w_q      <= '0;
      stripes_q    <= '0;
      stripe_cnt_q <= '0;
      rd_sel_q     <= 1'b0;
      wr_sel_q     <= 1'b0;
      rd_cnt_q     <= '0;
      shift_cnt_q  <= '0;
      shift_q      <= 1'b0;
      rd_last_q    <= '0;
      wr_last_q    <= '0;
      pipe_vld_q   <= '0;
      pipe_addr_q  <= '{default: '0};
    end else begin
      state_q      <= state_d;
      row_w_q      <= row_w_d;
      stripes_q    <= stripes_d;
      stripe_cnt_q <= stripe_cnt_d;
      rd_sel_q     <= rd_sel_d;
      wr_sel_q     <= wr_sel_d;
      rd_cnt_q     <= rd_cnt_d;
      shift_cnt_q  <= shift_cnt_d;
      shift_q      <= shift_d;
      rd_last_q    <= rd_last_d;
      wr_last_q    <= wr_last_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_addr_q  <= pipe_addr_d;
    end
  end

  // Addresses are live while strobed and otherwise hold the last strobed value.
  assign read_col_address  = (state_q == S_STREAM) ? rd_cnt_q[AW-1:0] : rd_last_q;
  assign write_col_address = wr_en_int ? wr_addr_int : wr_last_q;
  assign rd_buf_release    = (state_q == S_COMMIT) ? (rd_sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign wr_buf_commit     = (state_q == S_COMMIT) ? (wr_sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign rd_buffer_sel     = rd_sel_q;
  assign wr_buffer_sel     = wr_sel_q;
  assign shift_cols        = shift_q;
  assign wr_en_wr_buffer   = wr_en_int;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);

endmodule

// File: tb/tb_fpu_stripe_sequencer.sv
// Bench for fpu_stripe_sequencer: observed events are collected per cycle and compared with
// an event timeline derived from the stripe rules and the logged ready/free inputs.
module tb_fpu_stripe_sequencer;
  localparam int L  = 2;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   row_width = '0;
  logic [15:0]   num_stripes = '0;
  logic [1:0]    rd_buf_ready = '0;
  logic [1:0]    wr_buf_free = '0;
  logic [1:0]    rd_buf_release, wr_buf_commit;
  logic          rd_buffer_sel, wr_buffer_sel;
  logic [AW-1:0] read_col_address, write_col_address;
  logic          shift_cols, wr_en_wr_buffer, busy, done;

  fpu_stripe_sequencer #(.MEM_BUFFER_WIDTH(512), .COL_WIDTH(10), .MAC_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .row_width(row_width), .num_stripes(num_stripes),
    .rd_buf_ready(rd_buf_ready), .wr_buf_free(wr_buf_free),
    .rd_buf_release(rd_buf_release), .wr_buf_commit(wr_buf_commit),
    .rd_buffer_sel(rd_buffer_sel), .wr_buffer_sel(wr_buffer_sel),
    .read_col_address(read_col_address), .write_col_address(write_col_address),
    .shift_cols(shift_cols), .wr_en_wr_buffer(wr_en_wr_buffer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscmp = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event key = cycle*8 + kind; kinds: 0 read (seen at its shift cycle), 1 write,
  // 2 release, 3 commit, 4 done. Value = sel*1024 + address, or the mask.
  int       obs_ev[int];
  int       exp_ev[int];
  bit [3:0] in_log[int];
  int       prev_addr = 0;
  int       prev_sel = 0;
  bit       done_seen = 0;
  bit       commit_seen = 0;
  bit       rand_in = 0;

  always @(negedge clk) begin
    in_log[cyc] = {rd_buf_ready, wr_buf_free};
    if (!rst) begin
      if (shift_cols)          obs_ev[cyc*8+0] = prev_sel*1024 + prev_addr;
      if (wr_en_wr_buffer)     obs_ev[cyc*8+1] = int'(wr_buffer_sel)*1024 + int'(write_col_address);
      if (rd_buf_release != 0) obs_ev[cyc*8+2] = int'(rd_buf_release);
      if (wr_buf_commit != 0)  begin obs_ev[cyc*8+3] = int'(wr_buf_commit); commit_seen = 1; end
      if (done)                begin obs_ev[cyc*8+4] = 1; done_seen = 1; end
    end
    prev_addr = int'(read_col_address);
    prev_sel  = int'(rd_buffer_sel);
  end

  always @(posedge clk) begin
    #1;
    if (rand_in) begin
      rd_buf_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      wr_buf_free  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    end
  end

  task automatic set_inputs(input logic [1:0] r, input logic [1:0] f, input bit rnd);
    @(posedge clk); #2;
    rand_in = rnd; rd_buf_ready = r; wr_buf_free = f;
  endtask

  task automatic do_start(input int w, input int s, output int c0);
    obs_ev.delete(); done_seen = 0; commit_seen = 0;
    @(posedge clk); #1;
    row_width = (AW+1)'(w); num_stripes = 16'(s); start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_seen) begin ok = 1; break; end
    end
    repeat (8) @(posedge clk);
  endtask

  // Reference timeline: WAIT is entered the cycle after start (or after a commit); streaming
  // begins the cycle after the first WAIT cycle whose inputs show ready[sel] && free[sel].
  task automatic build_expected(input int c0, input int w, input int s);
    int wb, t, f, cm, sel;
    exp_ev.delete();
    if (w < 3 || s == 0) begin exp_ev[(c0+1)*8+4] = 1; return; end
    wb = c0 + 1;
    for (int k = 0; k < s; k++) begin
      sel = k % 2;
      t = wb;
      while (t < wb + 20000 && !(in_log.exists(t) && in_log[t][2+sel] && in_log[t][sel])) t++;
      f = t + 1;
      for (int i = 0; i < w; i++)     exp_ev[(f+i+1)*8+0] = sel*1024 + i;
      for (int j = 0; j < w - 2; j++) exp_ev[(f+j+3+L)*8+1] = sel*1024 + j;
      cm = f + w + L + 1;
      exp_ev[cm*8+2] = 1 << sel;
      exp_ev[cm*8+3] = 1 << sel;
      wb = cm + 1;
    end
    exp_ev[wb*8+4] = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({rd_buf_release, wr_buf_commit, rd_buffer_sel, wr_buffer_sel, read_col_address,
         write_col_address, shift_cols, wr_en_wr_buffer, busy, done} !== 28'd0) begin
      miscmp++;
      $display("FAIL reset_outputs: got busy=%0b rel=%b com=%b ra=%0d wa=%0d, expected all zero",
               busy, rd_buf_release, wr_buf_commit, read_col_address, write_col_address);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_stripe();
    int c0; bit ok;
    set_inputs(2'b11, 2'b11, 0);
    do_start(5, 1, c0);
    wait_done(200, ok);
    vecs++; if (!ok) begin miscmp++; $display("FAIL w5_timeout: done=0, expected done=1"); end
    build_expected(c0, 5, 1);
    vecs++;
    if (obs_ev.size() != exp_ev.size()) begin
      miscmp++; $display("FAIL w5_count: got %0d events, expected %0d", obs_ev.size(), exp_ev.size());
    end
    foreach (exp_ev[k]) begin
      vecs++;
      if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
        miscmp++;
        $display("FAIL w5_event cyc=%0d kind=%0d: got %0d, expected %0d", k/8, k%8,
                 obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
      end
    end
  endtask

  task automatic test_multi_stripe();
    int c0; bit ok;
    set_inputs(2'b11, 2'b11, 0);
    do_start(8, 3, c0);
    wait_done(400, ok);
    vecs++; if (!ok) begin miscmp++; $display("FAIL w8s3_timeout: done=0, expected done=1"); end
    build_expected(c0, 8, 3);
    vecs++;
    if (obs_ev.size() != exp_ev.size()) begin
      miscmp++; $display("FAIL w8s3_count: got %0d events, expected %0d", obs_ev.size(), exp_ev.size());
    end
    foreach (exp_ev[k]) begin
      vecs++;
      if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
        miscmp++;
        $display("FAIL w8s3_event cyc=%0d kind=%0d: got %0d, expected %0d", k/8, k%8,
                 obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
      end
    end
  endtask

  task automatic test_wait_hold();
    int c0; bit ok, seen;
    set_inputs(2'b11, 2'b01, 0);
    do_start(6, 2, c0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (commit_seen) begin seen = 1; break; end
    end
    vecs++; if (!seen) begin miscmp++; $display("FAIL hold_first_commit: commit=0, expected 1"); end
    repeat (20) @(posedge clk);
    #1 wr_buf_free = 2'b11;
    wait_done(200, ok);
    vecs++; if (!ok) begin miscmp++; $display("FAIL hold_timeout: done=0, expected done=1"); end
    build_expected(c0, 6, 2);
    vecs++;
    if (obs_ev.size() != exp_ev.size()) begin
      miscmp++; $display("FAIL hold_count: got %0d events, expected %0d", obs_ev.size(), exp_ev.size());
    end
    foreach (exp_ev[k]) begin
      vecs++;
      if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
        miscmp++;
        $display("FAIL hold_event cyc=%0d kind=%0d: got %0d, expected %0d", k/8, k%8,
                 obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
      end
    end
  endtask

  task automatic test_degenerate();
    int c0; bit ok;
    int ws[2] = '{2, 10};
    int ss[2] = '{3, 0};
    set_inputs(2'b11, 2'b11, 0);
    for (int n = 0; n < 2; n++) begin
      do_start(ws[n], ss[n], c0);
      wait_done(20, ok);
      vecs++;
      if (!ok) begin miscmp++; $display("FAIL degen_timeout w=%0d s=%0d: done=0, expected 1", ws[n], ss[n]); end
      build_expected(c0, ws[n], ss[n]);
      vecs++;
      if (obs_ev.size() != exp_ev.size()) begin
        miscmp++; $display("FAIL degen_count: got %0d events, expected %0d", obs_ev.size(), exp_ev.size());
      end
      foreach (exp_ev[k]) begin
        vecs++;
        if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
          miscmp++;
          $display("FAIL degen_event cyc=%0d kind=%0d: got %0d, expected %0d", k/8, k%8,
                   obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int c0; bit ok, hit;
    set_inputs(2'b11, 2'b11, 0);
    do_start(16, 1, c0);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (read_col_address == 9'd7 && shift_cols) begin hit = 1; break; end
    end
    vecs++; if (!hit) begin miscmp++; $display("FAIL midrst_reach7: addr=%0d, expected 7", read_col_address); end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({rd_buf_release, wr_buf_commit, read_col_address, write_col_address, shift_cols,
         wr_en_wr_buffer, busy, done, rd_buffer_sel, wr_buffer_sel} !== 28'd0) begin
      miscmp++;
      $display("FAIL midrst_outputs: got busy=%0b shift=%0b ra=%0d wa=%0d, expected all zero",
               busy, shift_cols, read_col_address, write_col_address);
    end
    @(posedge clk); #1 rst = 1'b0;
    do_start(16, 1, c0);
    wait_done(200, ok);
    vecs++; if (!ok) begin miscmp++; $display("FAIL midrst_timeout: done=0, expected done=1"); end
    build_expected(c0, 16, 1);
    vecs++;
    if (obs_ev.size() != exp_ev.size()) begin
      miscmp++; $display("FAIL midrst_count: got %0d events, expected %0d", obs_ev.size(), exp_ev.size());
    end
    foreach (exp_ev[k]) begin
      vecs++;
      if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
        miscmp++;
        $display("FAIL midrst_event cyc=%0d kind=%0d: got %0d, expected %0d", k/8, k%8,
                 obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
      end
    end
  endtask

  task automatic test_full_width();
    int c0; bit ok;
    set_inputs(2'b11, 2'b11, 0);
    do_start(512, 1, c0);
    repeat (100) @(posedge clk);
    #1 row_width = 10'd5; num_stripes = 16'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(700, ok);
    vecs++; if (!ok) begin miscmp++; $display("FAIL full_timeout: done=0, expected done=1"); end
    build_expected(c0, 512, 1);
    vecs++;
    if (obs_ev.size() != exp_ev.size()) begin
      miscmp++; $display("FAIL full_count: got %0d events, expected %0d", obs_ev.size(), exp_ev.size());
    end
    foreach (exp_ev[k]) begin
      vecs++;
      if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
        miscmp++;
        $display("FAIL full_event cyc=%0d kind=%0d: got %0d, expected %0d", k/8, k%8,
                 obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
      end
    end
    vecs++;
    if (busy !== 1'b0) begin miscmp++; $display("FAIL full_idle_after: busy=%0b, expected 0", busy); end
  endtask

  task automatic test_random();
    int c0, w, s; bit ok;
    for (int n = 0; n < 6; n++) begin
      w = $urandom_range(3, 40);
      s = $urandom_range(1, 4);
      set_inputs(2'b00, 2'b00, 1);
      do_start(w, s, c0);
      wait_done(s * (w + 200) + 200, ok);
      vecs++;
      if (!ok) begin miscmp++; $display("FAIL rand_timeout w=%0d s=%0d: done=0, expected 1", w, s); end
      build_expected(c0, w, s);
      vecs++;
      if (obs_ev.size() != exp_ev.size()) begin
        miscmp++;
        $display("FAIL rand_count w=%0d s=%0d: got %0d events, expected %0d", w, s, obs_ev.size(), exp_ev.size());
      end
      foreach (exp_ev[k]) begin
        vecs++;
        if (!obs_ev.exists(k) || obs_ev[k] !== exp_ev[k]) begin
          miscmp++;
          $display("FAIL rand_event w=%0d cyc=%0d kind=%0d: got %0d, expected %0d", w, k/8, k%8,
                   obs_ev.exists(k) ? obs_ev[k] : -1, exp_ev[k]);
        end
      end
    end
    set_inputs(2'b11, 2'b11, 0);
  endtask

  initial begin
    test_reset();
    test_single_stripe();
    test_multi_stripe();
    test_wait_hold();
    test_degenerate();
    test_mid_reset();
    test_full_width();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
